// File: rtl/nios2_c_to_hex_sched_pkg.sv
// rtl/nios2_c_to_hex_sched_pkg.sv - shared state encodings, constants and helpers for the to_hex scheduler
package nios2_c_to_hex_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DWELL = 2'd2
   } sched_state_t;

   localparam int         HEX_DATA_W      = 14;
   localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;

   function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (onehot[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/nios2_c_to_hex_sched_arbiter.sv
// rtl/nios2_c_to_hex_sched_arbiter.sv - round-robin one-hot arbiter with registered priority pointer
module nios2_c_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         update,
   input  logic [2:0]   last_grant,
   output logic [N-1:0] grant
);

   logic [2:0] ptr;
   logic       found;
   int         idx;

   // Scan from the pointer upward, wrapping, and keep the first requester found.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (update) begin
         ptr <= 3'((int'(last_grant) + 1) % N);
      end
   end

endmodule

// File: rtl/nios2_c_to_hex_sched.sv
// rtl/nios2_c_to_hex_sched.sv - time-multiplexed Avalon write master sharing the to_hex PIO
module nios2_c_to_hex_sched
   import nios2_c_to_hex_sched_pkg::*;
#(
   parameter int         N_REQ        = 4,
   parameter int         DATA_W       = HEX_DATA_W,
   parameter int         DWELL_CYCLES = 1000,
   parameter logic [1:0] PIO_ADDR     = PIO_DATA_OFFSET
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        ack,
   output logic [1:0]              m_address,
   output logic                    m_chipselect,
   output logic                    m_write_n,
   output logic [31:0]             m_writedata,
   output logic [2:0]              owner,
   output logic                    busy
);

   localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

   sched_state_t      state, state_next;
   logic [N_REQ-1:0]  grant;
   logic [2:0]        grant_index;
   logic [2:0]        owner_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  cnt;
   logic              take;

   assign take        = (state == IDLE) && (|req);
   assign grant_index = onehot_to_index(8'(grant));

   nios2_c_rr_arbiter #(.N(N_REQ)) u_arbiter (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .update     (state == WRITE),
      .last_grant (owner_q),
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (take) state_next = WRITE;
         WRITE:   state_next = DWELL;
         DWELL:   if (cnt == '0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Data is captured once at grant so later requester changes cannot leak onto the bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= '0;
         data_q  <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  owner_q <= grant_index;
                  data_q  <= req_data[int'(grant_index)*DATA_W +: DATA_W];
               end
            end
            WRITE:   cnt <= CNT_W'(DWELL_CYCLES - 1);
            DWELL:   if (cnt != '0) cnt <= cnt - 1'b1;
            default: cnt <= '0;
         endcase
      end
   end

   assign m_chipselect = (state == WRITE);
   assign m_write_n    = (state != WRITE);
   assign m_address    = PIO_ADDR;
   assign m_writedata  = 32'(data_q);
   assign ack          = (state == WRITE) ? (N_REQ'(1) << owner_q) : '0;
   assign owner        = owner_q;
   assign busy         = (state != IDLE);

endmodule
